// File: rtl/key_click_ctrl_if.sv
// key_click_ctrl_if: key pulse in, light/pattern state and click strobes out
interface key_click_ctrl_if #(
  parameter int NUM_PATTERNS = 7
);
  localparam int PAT_W = ($clog2(NUM_PATTERNS) > 1) ? $clog2(NUM_PATTERNS) : 1;
  logic             key_pulse;
  logic             light_on;
  logic [PAT_W-1:0] pattern_idx;
  logic             sgl_click;
  logic             dbl_click;
  logic             busy;
  modport master(output key_pulse, input light_on, pattern_idx, sgl_click, dbl_click, busy);
  modport slave(input key_pulse, output light_on, pattern_idx, sgl_click, dbl_click, busy);
endinterface

// File: rtl/key_click_ctrl.sv
// key_click_ctrl: classifies key pulses as single/double clicks driving light and pattern
module key_click_ctrl #(
  parameter int DBL_WINDOW   = 5000000,
  parameter int NUM_PATTERNS = 7
) (
  input logic             clk,
  input logic             reset,
  key_click_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(DBL_WINDOW);
  localparam int PAT_W = ($clog2(NUM_PATTERNS) > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(DBL_WINDOW - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
  typedef enum logic {IDLE, WAIT2} state_t;
  state_t           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic             light, light_n, sgl, sgl_n, dbl, dbl_n;
  // state, timer and every output are registered so nothing is combinational from key_pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tmr   <= '0;
      pat   <= '0;
      light <= 1'b0;
      sgl   <= 1'b0;
      dbl   <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      pat   <= pat_n;
      light <= light_n;
      sgl   <= sgl_n;
      dbl   <= dbl_n;
    end
  end
  // a pulse in WAIT2 wins over the timeout; the timer stops at the window end and never wraps
  always_comb begin
    state_n = state;
    tmr_n   = '0;
    pat_n   = pat;
    light_n = light;
    sgl_n   = 1'b0;
    dbl_n   = 1'b0;
    if (state == IDLE) begin
      state_n = bus.key_pulse ? WAIT2 : IDLE;
    end else if (bus.key_pulse) begin
      state_n = IDLE;
      dbl_n   = 1'b1;
      light_n = 1'b1;
      pat_n   = !light ? pat : (pat == PAT_LAST) ? '0 : pat + 1'b1;
    end else if (tmr == TMR_END) begin
      state_n = IDLE;
      sgl_n   = 1'b1;
      light_n = ~light;
    end else begin
      tmr_n = tmr + 1'b1;
    end
  end
  assign bus.light_on    = light;
  assign bus.pattern_idx = pat;
  assign bus.sgl_click   = sgl;
  assign bus.dbl_click   = dbl;
  assign bus.busy        = (state == WAIT2);
endmodule
